// File: rtl/pea_weight_loader.sv
// pea_weight_loader: fetches one 3x3 filter (9 bytes) from weight memory,
// stages it, then presents it to the filter weight ports with a one-cycle
// Weight_en strobe, holding it stable for PEA_NUM cycles so every lane of the
// filter's Weight_en delay line captures the same set.
module pea_weight_loader #(
  parameter int PEA_NUM = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  filter_idx,
  output logic        mem_rd_en,
  output logic [11:0] mem_addr,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  Weight1,
  output logic [7:0]  Weight2,
  output logic [7:0]  Weight3,
  output logic [7:0]  Weight4,
  output logic [7:0]  Weight5,
  output logic [7:0]  Weight6,
  output logic [7:0]  Weight7,
  output logic [7:0]  Weight8,
  output logic [7:0]  Weight9,
  output logic        Weight_en,
  output logic        busy,
  output logic        done
);

  localparam int HW = (PEA_NUM > 1) ? $clog2(PEA_NUM) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(PEA_NUM - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    DRAIN = 3'd2,
    LOAD  = 3'd3,
    HOLD  = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t          state, state_n;
  logic [3:0]      k, k_n;
  logic [HW-1:0]   hcnt, hcnt_n;
  logic [7:0]      idx_lat, idx_n;
  logic [11:0]     addr_n;
  logic            rd_en_q;
  logic [3:0]      rd_k_q;
  logic [8:0][7:0] stage;

  // Next-state, counter and next-address logic.
  always_comb begin
    state_n = state;
    k_n     = k;
    hcnt_n  = hcnt;
    idx_n   = idx_lat;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = FETCH;
          k_n     = '0;
          idx_n   = filter_idx;
        end
      end
      FETCH: begin
        if (k == 4'd8) begin
          state_n = DRAIN;
          k_n     = '0;
        end else begin
          k_n = k + 4'd1;
        end
      end
      DRAIN: state_n = LOAD;
      LOAD: begin
        state_n = HOLD;
        hcnt_n  = '0;
      end
      HOLD: begin
        if (hcnt == HOLD_LAST) begin
          state_n = DONE;
          hcnt_n  = '0;
        end else begin
          hcnt_n = hcnt + 1'b1;
        end
      end
      DONE: begin
        if (start) begin
          state_n = FETCH;
          k_n     = '0;
          idx_n   = filter_idx;
        end else begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
        k_n     = '0;
        hcnt_n  = '0;
      end
    endcase
    // Max 255*9+8 = 2303, fits 12 bits without wrap.
    addr_n = ({4'b0000, idx_n} * 12'd9) + {8'b0000_0000, k_n};
  end

  // State, counters, latched index and registered memory strobe/address.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      k         <= '0;
      hcnt      <= '0;
      idx_lat   <= '0;
      mem_rd_en <= 1'b0;
      mem_addr  <= '0;
    end else begin
      state     <= state_n;
      k         <= k_n;
      hcnt      <= hcnt_n;
      idx_lat   <= idx_n;
      mem_rd_en <= (state_n == FETCH);
      mem_addr  <= (state_n == FETCH) ? addr_n : '0;
    end
  end

  // Track which read the returning data belongs to and stage it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_en_q <= 1'b0;
      rd_k_q  <= '0;
      stage   <= '0;
    end else begin
      rd_en_q <= mem_rd_en;
      rd_k_q  <= k;
      if (rd_en_q) begin
        stage[rd_k_q] <= mem_rdata;
      end
    end
  end

  // Weight output registers, updated on the DRAIN->LOAD edge so the new set
  // is visible during LOAD. Read 8 is staged on that same edge, so Weight9
  // takes it straight from mem_rdata.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      Weight1 <= '0;
      Weight2 <= '0;
      Weight3 <= '0;
      Weight4 <= '0;
      Weight5 <= '0;
      Weight6 <= '0;
      Weight7 <= '0;
      Weight8 <= '0;
      Weight9 <= '0;
    end else if (state == DRAIN) begin
      Weight1 <= stage[0];
      Weight2 <= stage[1];
      Weight3 <= stage[2];
      Weight4 <= stage[3];
      Weight5 <= stage[4];
      Weight6 <= stage[5];
      Weight7 <= stage[6];
      Weight8 <= stage[7];
      Weight9 <= mem_rdata;
    end
  end

  // Status outputs decoded from the registered state.
  always_comb begin
    Weight_en = (state == LOAD);
    done      = (state == DONE);
    busy      = (state == FETCH) || (state == DRAIN) ||
                (state == LOAD)  || (state == HOLD);
  end

endmodule

// File: tb/tb_pea_weight_loader.sv
// Bench for pea_weight_loader: table of filter loads, memory model returning
// mem[a] = a[7:0], scoreboard queues for addresses and weight sets.
module tb_pea_weight_loader;

  localparam int P = 4;
  localparam int LAST_C = 12 + P;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  filter_idx;
  logic        mem_rd_en;
  logic [11:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic [7:0]  Weight1, Weight2, Weight3, Weight4, Weight5;
  logic [7:0]  Weight6, Weight7, Weight8, Weight9;
  logic        Weight_en;
  logic        busy;
  logic        done;

  pea_weight_loader #(.PEA_NUM(P)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .filter_idx(filter_idx),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .Weight1(Weight1), .Weight2(Weight2), .Weight3(Weight3),
    .Weight4(Weight4), .Weight5(Weight5), .Weight6(Weight6),
    .Weight7(Weight7), .Weight8(Weight8), .Weight9(Weight9),
    .Weight_en(Weight_en), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Weight memory: word a holds a[7:0]; filler value when not read.
  always @(posedge clk) begin
    mem_rdata <= mem_rd_en ? mem_addr[7:0] : 8'hEE;
  end

  int n_cmp = 0;
  int n_bad = 0;

  logic [11:0] aq[$];
  logic [71:0] wq[$];
  logic [71:0] cur_w;

  function automatic logic [71:0] wvec();
    return {Weight1, Weight2, Weight3, Weight4, Weight5,
            Weight6, Weight7, Weight8, Weight9};
  endfunction

  function automatic logic [71:0] wset(input logic [11:0] first);
    logic [71:0] v;
    logic [11:0] a;
    v = '0;
    for (int j = 0; j < 9; j++) begin
      a = first + 12'(j);
      v[(8 - j) * 8 +: 8] = a[7:0];
    end
    return v;
  endfunction

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [11:0] first);
    for (int j = 0; j < 9; j++) aq.push_back(first + 12'(j));
    wq.push_back(wset(first));
  endtask

  // Scoreboard monitor: every read address and every Weight_en set popped here.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && mem_rd_en === 1'b1) begin
      n_cmp++;
      if (aq.size() == 0) begin
        n_bad++;
        $display("FAIL addr_unexpected: got %0d expected no read", mem_addr);
      end else begin
        logic [11:0] ea;
        ea = aq.pop_front();
        if (mem_addr !== ea) begin
          n_bad++;
          $display("FAIL addr: got %0d expected %0d", mem_addr, ea);
        end
      end
    end
    if (Weight_en === 1'b1) begin
      n_cmp++;
      if (wq.size() == 0) begin
        n_bad++;
        $display("FAIL wen_unexpected: got Weight_en=1 expected 0");
      end else begin
        logic [71:0] ew;
        ew = wq.pop_front();
        if (wvec() !== ew) begin
          n_bad++;
          $display("FAIL weight_set: got %0h expected %0h", wvec(), ew);
        end
      end
    end
  end

  typedef struct {
    logic [7:0]  idx;
    logic [11:0] first;
    logic [7:0]  last_w;
    bit          pre;
    bit          chain;
    bit          poke;
    bit          jit;
  } vec_t;

  vec_t tbl[5];

  // One full load, checking per-cycle status; cycle c is the c-th cycle
  // after the edge that accepted start.
  task automatic run_load(input vec_t v, input vec_t nxt);
    logic [71:0] nw;
    nw = wset(v.first);
    if (!v.pre) begin
      @(negedge clk);
      rst_n = 1'b1;
      start = 1'b1;
      filter_idx = v.idx;
      push_exp(v.first);
    end
    for (int c = 1; c <= LAST_C; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (v.jit) filter_idx = 8'($urandom_range(255));
      if (v.poke && c == 12) begin
        start = 1'b1;
        filter_idx = 8'd7;
      end
      if (c == 11) cur_w = nw;
      chk("busy", 72'(busy), 72'(c <= LAST_C - 1));
      chk("done", 72'(done), 72'(c == LAST_C));
      chk("rd_en", 72'(mem_rd_en), 72'(c <= 9));
      chk("wen", 72'(Weight_en), 72'(c == 11));
      chk("weights", wvec(), cur_w);
      if (v.chain && c == LAST_C) begin
        start = 1'b1;
        filter_idx = nxt.idx;
        push_exp(nxt.first);
      end
    end
    chk("w9_table", 72'(Weight9), 72'(v.last_w));
  endtask

  initial begin
    int done_cnt;
    vec_t r0;
    rst_n = 1'b0;
    start = 1'b0;
    filter_idx = 8'd0;
    cur_w = '0;

    tbl[0] = '{8'd2,   12'd18,   8'd26,  1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{8'd255, 12'd2295, 8'hFF,  1'b0, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{8'd1,   12'd9,    8'd17,  1'b1, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{8'd100, 12'd900,  8'h8C,  1'b0, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{8'd28,  12'd252,  8'h04,  1'b0, 1'b0, 1'b0, 1'b0};

    repeat (3) @(negedge clk);
    chk("rst_rd_en", 72'(mem_rd_en), 72'(0));
    chk("rst_addr", 72'(mem_addr), 72'(0));
    chk("rst_weights", wvec(), 72'(0));
    chk("rst_wen", 72'(Weight_en), 72'(0));
    chk("rst_busy", 72'(busy), 72'(0));
    chk("rst_done", 72'(done), 72'(0));

    // Entry 0 releases reset and starts in the same cycle.
    for (int i = 0; i < 5; i++) begin
      run_load(tbl[i], tbl[(i + 1) % 5]);
    end

    // Reset in the middle of FETCH.
    @(negedge clk);
    start = 1'b1;
    filter_idx = 8'd3;
    push_exp(12'd27);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 5) rst_n = 1'b0;
    end
    @(negedge clk);
    rst_n = 1'b1;
    aq.delete();
    wq.delete();
    cur_w = '0;
    chk("abort_rd_en", 72'(mem_rd_en), 72'(0));
    chk("abort_addr", 72'(mem_addr), 72'(0));
    chk("abort_weights", wvec(), 72'(0));
    chk("abort_wen", 72'(Weight_en), 72'(0));
    chk("abort_busy", 72'(busy), 72'(0));
    chk("abort_done", 72'(done), 72'(0));
    done_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
    end
    chk("abort_no_done", 72'(done_cnt), 72'(0));
    chk("abort_idle_busy", 72'(busy), 72'(0));

    r0 = '{8'd0, 12'd0, 8'd8, 1'b0, 1'b0, 1'b0, 1'b0};
    run_load(r0, r0);
    chk("final_set", wvec(), 72'h00_01_02_03_04_05_06_07_08);

    repeat (3) @(negedge clk);
    chk("addr_q_empty", 72'(aq.size()), 72'(0));
    chk("wset_q_empty", 72'(wq.size()), 72'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pea_weight_loader.md
PEA_WEIGHT_LOADER -- requirements
Module: pea_weight_loader

Interface
REQ-001: Parameter PEA_NUM, default 4, SHALL set the number of PE-array lanes the weight set is broadcast to; it matches the codebase PEA_num value.
REQ-002: clk  input  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-003: rst_n  input  1  reset; SHALL be synchronous and active-low.
REQ-004: start  input  1  request to load one 3x3 filter.
REQ-005: filter_idx  input  8  index of the filter to load; SHALL be latched when start is accepted.
REQ-006: mem_rd_en  output  1  weight-memory read strobe.
REQ-007: mem_addr  output  12  weight-memory word address.
REQ-008: mem_rdata  input  8  weight-memory read data; valid exactly one cycle after mem_rd_en.
REQ-009: Weight1..Weight9  output  8 each  weight set, row-major (Weight1 = top-left, Weight9 = bottom-right), driven to the filter weight ports.
REQ-010: Weight_en  output  1  one-cycle load strobe to the filter.
REQ-011: busy  output  1  high while a load is in progress.
REQ-012: done  output  1  one-cycle completion pulse.

Function
REQ-013: The FSM SHALL have states IDLE, FETCH, DRAIN, LOAD, HOLD and DONE, all held in registers.
REQ-014: IDLE -> FETCH when start=1; start SHALL be accepted only in IDLE or DONE, and ignored in all other states.
REQ-015: FETCH SHALL last exactly 9 cycles, with k = 0..8.
 - mem_rd_en=1 every cycle.
 - mem_addr = filter_idx_latched*9 + k, computed unsigned in 12 bits; maximum is 2303, with no overflow.
REQ-016: mem_rd_en and mem_addr SHALL be registered outputs.
 - If start is sampled at edge E0, the reads appear in cycles C1..C9.
 - mem_rd_en SHALL be 0 outside FETCH.
REQ-017: mem_rdata SHALL be captured into internal staging register k one cycle after read k is issued (cycles C2..C10); DRAIN (C10) exists only to capture read 8.
REQ-018: Weight outputs SHALL NOT change during FETCH or DRAIN.
REQ-019: LOAD (C11), in a single cycle:
 - Weight1..9 SHALL be updated from staging registers 0..8 (staging k -> Weight(k+1)).
 - Weight_en SHALL be 1 for exactly that one cycle.
REQ-020: HOLD SHALL last exactly PEA_NUM cycles (C12..C11+PEA_NUM).
 - Weight outputs SHALL be held stable from LOAD through the end of HOLD, so that every lane of the filter's PEA_NUM-stage Weight_en delay line captures the same set.
REQ-021: DONE SHALL last one cycle (C12+PEA_NUM).
 - done=1 and busy=0.
 - If start=1 in DONE -> FETCH, giving back-to-back loads; otherwise -> IDLE.
REQ-022: busy SHALL be 1 in FETCH, DRAIN, LOAD and HOLD, and 0 in IDLE and DONE.
REQ-023: Weight outputs SHALL retain the last loaded set indefinitely in IDLE and DONE.
REQ-024: A start asserted in FETCH through HOLD SHALL have no effect: no restart and no change to the latched filter_idx.
REQ-025: filter_idx changes after acceptance SHALL NOT affect the addresses of the load in progress.

Reset
REQ-026: rst_n=0 sampled at a clock edge SHALL force the following values from that edge:
 - state=IDLE, k counter=0, HOLD counter=0;
 - Weight1..9=0, staging registers=0, latched filter_idx=0;
 - mem_rd_en=0, mem_addr=0, Weight_en=0, busy=0, done=0.
REQ-027: Reset asserted mid-operation (any state) SHALL abort the load with no Weight_en pulse and no done pulse. Read data returning after reset SHALL be discarded.
REQ-028: Following reset release, the block SHALL accept start on the first cycle rst_n=1 is sampled.

Verification
REQ-029: Basic load.
 - Stimulus: memory word a holds a[7:0]; start=1 with filter_idx=2 for one cycle, PEA_NUM=4.
 - Expected: mem_addr 18..26 in C1..C9.
 - Expected: Weight1..9 = 18..26 and Weight_en=1 in C11.
 - Expected: weights stable through C15; done in C16; busy=1 in C1..C15.
REQ-030: Maximum index.
 - Stimulus: filter_idx=255.
 - Expected: addresses 2295..2303 with no wrap; Weight9 = mem[2303].
REQ-031: Ignored start and back-to-back.
 - Stimulus: start pulsed during HOLD with filter_idx=7.
 - Expected: ignored, with no address change.
 - Stimulus: start=1 in the DONE cycle with filter_idx=1.
 - Expected: FETCH begins the next cycle at mem_addr=9.
 - Expected: Weight outputs keep the old set until the new LOAD.
REQ-032: Reset mid-FETCH.
 - Stimulus: rst_n=0 at C5 for one cycle.
 - Expected: all outputs 0 from that edge; no Weight_en and no done afterwards.
 - Expected: a new start with filter_idx=0 loads mem[0..8] correctly.
REQ-033: Index change after acceptance.
 - Stimulus: filter_idx changes in every cycle after start is accepted.
 - Expected: addresses follow only the value latched at acceptance.
